// File: rtl/un_striping_nlane.sv
// Round-robin merge of LANES parallel lanes into one valid/ready stream.
// Each lane has its own DEPTH-entry FIFO so that skew between lanes is absorbed.
module un_striping_nlane #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned LANES = 2,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk_f,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic [LANES-1:0]       lane_valid,
  output logic [LANES-1:0]       lane_ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [LANES-1:0]       overflow,
  output logic [PW-1:0]          rr_ptr
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] RR_LAST = PW'(LANES - 1);

  logic [WIDTH-1:0] r_mem [LANES][DEPTH];
  logic [AW-1:0]    r_wr  [LANES];
  logic [AW-1:0]    r_rd  [LANES];
  logic [AW:0]      r_cnt [LANES];
  logic [LANES-1:0] r_ovf;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [PW-1:0]    r_rr;

  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_empty;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic             w_load;
  logic [WIDTH-1:0] w_head;
  logic [PW-1:0]    w_rr_next;

  always_comb begin
    w_full    = '0;
    w_empty   = '0;
    w_push    = '0;
    w_pop     = '0;
    w_load    = 1'b0;
    w_head    = '0;
    w_rr_next = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_full[k]  = (r_cnt[k] == CNT_FULL);
      w_empty[k] = (r_cnt[k] == '0);
      // A push into a full FIFO is dropped even if the same lane pops this cycle.
      w_push[k]  = lane_valid[k] & ~w_full[k];
    end
    w_load = (~r_valid | ready_in) & ~w_empty[r_rr];
    for (int unsigned k = 0; k < LANES; k++) begin
      w_pop[k] = w_load & (r_rr == PW'(k));
    end
    w_head = r_mem[r_rr][r_rd[r_rr]];
    // With LANES=1 RR_LAST is 0, so the pointer is pinned at 0.
    w_rr_next = (r_rr == RR_LAST) ? '0 : r_rr + 1'b1;
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        r_wr[k]  <= '0;
        r_rd[k]  <= '0;
        r_cnt[k] <= '0;
      end
      r_ovf   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_rr    <= '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (w_push[k]) begin
          r_mem[k][r_wr[k]] <= lane_data[k*WIDTH +: WIDTH];
          r_wr[k]           <= r_wr[k] + 1'b1;
        end
        if (w_pop[k]) r_rd[k] <= r_rd[k] + 1'b1;
        if (w_push[k] && !w_pop[k])      r_cnt[k] <= r_cnt[k] + 1'b1;
        else if (!w_push[k] && w_pop[k]) r_cnt[k] <= r_cnt[k] - 1'b1;
        if (lane_valid[k] && w_full[k]) r_ovf[k] <= 1'b1;
      end
      if (w_load) begin
        r_data  <= w_head;
        r_valid <= 1'b1;
        r_rr    <= w_rr_next;
      end else if (ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign lane_ready = reset ? '0 : ~w_full;
  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign overflow   = r_ovf;
  assign rr_ptr     = r_rr;

endmodule
